// File: rtl/kernel_arbiter.sv
// Round-robin front end for a combinational compute kernel: accepts one request at a
// time, gives the kernel KLAT settling cycles, then holds the captured result until consumed.
module kernel_arbiter #(
    parameter int NREQ = 3,
    parameter int KLAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_data,
    output logic [63:0]          k_in,
    input  logic [63:0]          k_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [63:0]          rsp_data,
    output logic                 busy,
    output logic [15:0]          done_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   kin_q, kin_d;
    logic          rvld_q, rvld_d;
    logic [1:0]    rid_q, rid_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [15:0]   done_q, done_d;

    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Search starts just past the last served requester, wrapping modulo NREQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ))
                sum = sum - (IW+1)'(NREQ);
            cand = sum[IW-1:0];
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_vld && rst_n)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        kin_d   = kin_q;
        rvld_d  = rvld_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    kin_d   = req_data[64*int'(gnt_idx) +: 64];
                    gid_d   = gnt_idx;
                    cnt_d   = 4'(KLAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = k_out;
                    rid_d   = 2'(gid_q);
                    rvld_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rvld_d  = 1'b0;
                    ptr_d   = gid_q;
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ-1);
            gid_q   <= '0;
            cnt_q   <= '0;
            kin_q   <= '0;
            rvld_q  <= 1'b0;
            rid_q   <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            kin_q   <= kin_d;
            rvld_q  <= rvld_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign k_in      = kin_q;
    assign rsp_valid = rvld_q;
    assign rsp_id    = rid_q;
    assign rsp_data  = rdata_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_q;
endmodule

// File: tb/tb_kernel_arbiter.sv
// Bench for kernel_arbiter: a timeline model (grant cycle -> response cycle) predicts
// every output each cycle under directed and random traffic; a second instance covers KLAT=0, NREQ=2.
module tb_kernel_arbiter;
    localparam int KLAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req_valid, req_ready;
    logic [191:0] req_data;
    logic [63:0]  k_in, k_out, rsp_data;
    logic         rsp_valid, rsp_ready, busy;
    logic [1:0]   rsp_id;
    logic [15:0]  done_cnt;

    logic [1:0]   req_valid2, req_ready2;
    logic [127:0] req_data2;
    logic [63:0]  k_in2, k_out2, rsp_data2;
    logic         rsp_valid2, rsp_ready2, busy2;
    logic [1:0]   rsp_id2;
    logic [15:0]  done_cnt2;

    bit kfix = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    // model state
    bit          inflight;
    int          c, rsp_cycle, last, p_id, cur_id;
    logic [63:0] p_data, cur_data, exp_kin;
    logic [15:0] done_m;

    function automatic logic [63:0] kf(input logic [63:0] x, input bit fx);
        return fx ? 64'hAAAA_5555_F0F0_0F0F : {x[31:0] + x[63:32], x[63:32] ^ x[31:0]};
    endfunction

    assign k_out  = kf(k_in, kfix);
    assign k_out2 = k_in2 ^ 64'hFFFF_0000_FFFF_0000;

    always #5 clk = ~clk;

    kernel_arbiter #(.NREQ(3), .KLAT(KLAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .k_in(k_in), .k_out(k_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
        .done_cnt(done_cnt));

    kernel_arbiter #(.NREQ(2), .KLAT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_data(req_data2), .k_in(k_in2), .k_out(k_out2), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready2), .rsp_id(rsp_id2), .rsp_data(rsp_data2), .busy(busy2),
        .done_cnt(done_cnt2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight = 1'b0; last = 2; done_m = '0; exp_kin = '0;
        cur_id = 0; cur_data = '0; rsp_cycle = 0;
    endtask

    // One cycle: drive at negedge, check every output against the model, advance.
    task automatic step(input logic [2:0] rv, input logic [191:0] d, input logic rr);
        bit         rvld;
        int         g;
        logic [2:0] exp_rdy;
        req_valid = rv; req_data = d; rsp_ready = rr;
        #1;
        if (inflight && c == rsp_cycle) begin
            cur_id = p_id; cur_data = p_data;
        end
        rvld = inflight && (c >= rsp_cycle);
        g = -1;
        exp_rdy = '0;
        if (!inflight)
            for (int k = 1; k <= 3; k++)
                if (g < 0 && rv[(last + k) % 3]) g = (last + k) % 3;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(rvld));
        chk("rsp_id",    64'(rsp_id),    64'(cur_id));
        chk("rsp_data",  rsp_data,       cur_data);
        chk("busy",      64'(busy),      64'(inflight));
        chk("k_in",      k_in,           exp_kin);
        chk("done_cnt",  64'(done_cnt),  64'(done_m));
        if (g >= 0) begin
            inflight  = 1'b1;
            rsp_cycle = c + KLAT + 2;
            p_id      = g;
            exp_kin   = d[64*g +: 64];
            p_data    = kf(exp_kin, kfix);
        end else if (rvld && rr) begin
            inflight = 1'b0;
            last     = cur_id;
            done_m   = done_m + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        c++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 3'b111;
        #1;
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_done_cnt",  64'(done_cnt),  64'd0);
        chk("rst_k_in",      k_in,           64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_data",  rsp_data,       64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1 chk("rst_req_ready_hold", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        c++;
    endtask

    function automatic logic [191:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        c = 0;
        req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        req_valid2 = '0; req_data2 = '0; rsp_ready2 = 1'b0;
        model_reset();
        rst_n = 1'b0;
        req_valid = 3'b111;
        req_valid2 = 2'b11;
        #1;
        chk("init_req_ready",  64'(req_ready),  64'd0);
        chk("init_req_ready2", 64'(req_ready2), 64'd0);
        chk("init_busy",       64'(busy),       64'd0);
        chk("init_k_in",       k_in,            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0; req_valid2 = '0;

        // KLAT=0, NREQ=2: ptr resets to 1, so requester 1 wins when alone; response at T+2
        req_valid2 = 2'b10;
        req_data2  = {64'h1111_2222_3333_4444, 64'h0};
        #1 chk("k0_req_ready", 64'(req_ready2), 64'(2'b10));
        @(negedge clk);
        req_valid2 = 2'b00;
        #1;
        chk("k0_T1_rsp_valid", 64'(rsp_valid2), 64'd0);
        chk("k0_T1_busy",      64'(busy2),      64'd1);
        chk("k0_T1_k_in",      k_in2,           64'h1111_2222_3333_4444);
        @(negedge clk);
        rsp_ready2 = 1'b1;
        #1;
        chk("k0_T2_rsp_valid", 64'(rsp_valid2), 64'd1);
        chk("k0_T2_rsp_id",    64'(rsp_id2),    64'd1);
        chk("k0_T2_rsp_data",  rsp_data2,       64'hEEEE_2222_CCCC_4444);
        @(negedge clk);
        rsp_ready2 = 1'b0;
        #1;
        chk("k0_done_cnt",   64'(done_cnt2),  64'd1);
        chk("k0_rsp_valid0", 64'(rsp_valid2), 64'd0);
        chk("k0_busy0",      64'(busy2),      64'd0);

        // single request with fixed kernel output
        kfix = 1'b1;
        step(3'b001, {128'h0, 64'h0001_0002_0003_0004}, 1'b1);
        for (int i = 0; i < 6; i++) step(3'b000, '0, 1'b1);
        kfix = 1'b0;
        chk("single_done_cnt", 64'(done_cnt), 64'd1);

        // contention, all requesters held
        for (int i = 0; i < 30; i++) step(3'b111, rnd_data(), 1'b1);

        // backpressure: ten-plus cycles in RESP with rsp_ready low
        step(3'b001, rnd_data(), 1'b0);
        for (int i = 0; i < 14; i++) step(3'b111, rnd_data(), 1'b0);
        step(3'b000, '0, 1'b1);

        // withdrawn request during RESP, then full contention
        step(3'b100, rnd_data(), 1'b0);
        for (int i = 0; i < 4; i++) step(3'b000, '0, 1'b0);
        step(3'b010, rnd_data(), 1'b0);
        step(3'b000, '0, 1'b1);
        step(3'b000, '0, 1'b1);
        step(3'b111, rnd_data(), 1'b1);
        for (int i = 0; i < 5; i++) step(3'b000, '0, 1'b1);

        // reset mid-WAIT, then 110 must go to requester 1
        step(3'b001, rnd_data(), 1'b1);
        step(3'b000, '0, 1'b1);
        do_reset();
        step(3'b110, rnd_data(), 1'b1);
        for (int i = 0; i < 5; i++) step(3'b000, '0, 1'b1);

        // random traffic
        for (int i = 0; i < 800; i++)
            step(3'($urandom_range(0, 7)), rnd_data(), ($urandom_range(0, 3) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
